// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider (signed/unsigned).
// One quotient bit per cycle, MSB first; busy stalls the pipeline meanwhile.
// Divide by zero completes in one cycle with quotient all ones and the
// dividend passed through as remainder.
// Optional build macro DIV_EARLY_OUT_EN: trivial cases (|divisor| > |dividend|,
// or |divisor| == 1) also complete in one cycle instead of WIDTH+1.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Partial remainder; always < |divisor| between iterations, so WIDTH bits suffice.
    logic [WIDTH-1:0] prem_q, prem_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Operand magnitudes and sign flags seen at capture time.
    logic             sgn_dvd, sgn_dvs;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;

    assign sgn_dvd = signed_div & dividend[WIDTH-1];
    assign sgn_dvs = signed_div & divisor[WIDTH-1];
    assign mag_dvd = sgn_dvd ? -dividend : dividend;
    assign mag_dvs = sgn_dvs ? -divisor  : divisor;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    logic [WIDTH:0]   shifted, trial;
    logic             qbit;
    logic [WIDTH-1:0] step_prem, step_work;

    always_comb begin
        shifted   = {prem_q, work_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr_q};
        qbit      = ~trial[WIDTH];
        step_prem = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_work = {work_q[WIDTH-2:0], qbit};
    end

    // Next-state, operand capture, iteration and result commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && !annul) begin
                    negq_d = sgn_dvd ^ sgn_dvs;
                    negr_d = sgn_dvd;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag_dvs > mag_dvd) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rem_d   = dividend;
                        dbz_d   = 1'b0;
                    end else if (mag_dvs == WIDTH'(1)) begin
                        state_d = DONE;
                        quo_d   = (sgn_dvd ^ sgn_dvs) ? -mag_dvd : mag_dvd;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = CALC;
                        prem_d  = '0;
                        work_d  = mag_dvd;
                        dvsr_d  = mag_dvs;
                    end
                end
            end
            CALC: begin
                if (annul) begin
                    // Flush: drop the in-flight op, keep previous results.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    prem_d = step_prem;
                    work_d = step_work;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        quo_d   = negq_q ? -step_work : step_work;
                        rem_d   = negr_q ? -step_prem : step_prem;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (WIDTH=32). Expected results are
// computed with 64-bit integer arithmetic when an op is launched and compared
// when done pulses. Honours DIV_EARLY_OUT_EN for expected latency.
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic         annul;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa, sb, ma, mb, q64, r64;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q64   = sa / sb;
            r64   = sa % sb;
            e.q   = q64[W-1:0];
            e.r   = r64[W-1:0];
            e.dbz = 1'b0;
            e.lat = W + 1;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
            if (mb > ma || mb == 1) e.lat = 1;
`else
            if (mb > ma + 64'sd1_0000_0000_0000) e.lat = 0; // unreachable for 32-bit operands
`endif
        end
        return e;
    endfunction

    // Drive one start pulse in cycle 0 and record the expectation.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend   = a;
        divisor    = b;
        signed_div = s;
        start      = 1'b1;
        exp_q.push_back(model(a, b, s));
    endtask

    // Called at the negedge of cycle 1; holds start high through cycle 'hold'.
    task automatic wait_result(input int hold);
        int   n;
        bit   busy_ok;
        exp_t e;
        n       = 1;
        busy_ok = 1'b1;
        start   = (hold >= 1);
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
            start = (n <= hold);
            if (start) dividend = dividend + 32'd1;
        end
        start = 1'b0;
        if (!done) begin
            check_val("timeout_done", {31'b0, done}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_val("unexpected_done", {31'b0, done}, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val("latency", n, e.lat);
        check_val("quotient", quotient, e.q);
        check_val("remainder", remainder, e.r);
        check_val("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        check_val("busy_during_op", {31'b0, busy_ok & busy}, 32'd1);
        $display("op done: lat=%0d q=%h r=%h dbz=%0b (exp q=%h r=%h dbz=%0b lat=%0d)",
                 n, quotient, remainder, div_by_zero, e.q, e.r, e.dbz, e.lat);
        last_q   = e.q;
        last_r   = e.r;
        last_dbz = e.dbz;
        @(negedge clk);
        check_val("done_one_cycle", {31'b0, done}, 32'd0);
        check_val("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        launch(a, b, s);
        @(negedge clk);
        wait_result(0);
    endtask

    initial begin
        int dones;
        bit early_done;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_quotient", quotient, 32'd0);
        check_val("rst_remainder", remainder, 32'd0);
        check_val("rst_dbz", {31'b0, div_by_zero}, 32'd0);

        // Directed ops
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFFFF9C, 32'd7, 1'b1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_op(32'h12345678, 32'd0, 1'b0);
        run_op(32'd3, 32'd10, 1'b0);
        run_op(32'hFFFFFFF7, 32'd1, 1'b1);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0);
        run_op(32'h80000000, 32'd3, 1'b0);
        run_op(32'd77, 32'hFFFFFFF6, 1'b1);

        // Random ops, mixed sign modes
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
            run_op(a, b, i[0]);
        end

        // start with annul in IDLE is ignored
        @(negedge clk);
        dividend = 32'd9; divisor = 32'd3; signed_div = 1'b0;
        start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check_val("start_annul_idle_busy", {31'b0, busy}, 32'd0);

        // Flush: annul in cycle 10 of 50/5, new start accepted in cycle 11
        launch(32'd50, 32'd5, 1'b0);
        void'(exp_q.pop_back());
        early_done = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) early_done = 1'b1;
            annul = (n == 10);
        end
        check_val("flush_no_done", {31'b0, early_done}, 32'd0);
        check_val("flush_busy", {31'b0, busy}, 32'd0);
        check_val("flush_hold_q", quotient, last_q);
        check_val("flush_hold_r", remainder, last_r);
        check_val("flush_hold_dbz", {31'b0, div_by_zero}, {31'b0, last_dbz});
        dividend = 32'd1000; divisor = 32'd9; signed_div = 1'b0; start = 1'b1;
        exp_q.push_back(model(32'd1000, 32'd9, 1'b0));
        @(negedge clk);
        wait_result(0);

        // Back-pressure: start held through cycles 1..20 yields one done
        launch(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        wait_result(20);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("backpressure_extra_done", dones, 32'd0);

        // Reset in cycle 15 of a divide
        launch(32'd200, 32'd3, 1'b0);
        void'(exp_q.pop_back());
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (n == 15);
        end
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_done", {31'b0, done}, 32'd0);
        check_val("midrst_quotient", quotient, 32'd0);
        check_val("midrst_remainder", remainder, 32'd0);
        check_val("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("midrst_no_done", dones, 32'd0);
        check_val("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider in the EX stage.
- Handles signed and unsigned DIV/DIVU.
- Its quotient and remainder are operands of the EX result-select mux, and separately feed the HI/LO write path.
- Stalls the pipeline via busy while iterating.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a divide; sampled only in IDLE
signed_div  input  1  1 = two's-complement signed, 0 = unsigned; sampled with start
annul  input  1  abort in-flight divide (pipeline flush)
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient; held until next accepted start
remainder  output  WIDTH  registered remainder; held until next accepted start
div_by_zero  output  1  registered flag for last completed op; held with results

Behaviour:
- Reset: the reset is synchronous active-high, using ports clk and rst. On reset, state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and the iteration counter is 0. Reset mid-operation discards all work.
- States: IDLE, CALC, DONE. Transitions:
  - IDLE->CALC on start.
  - CALC->DONE after WIDTH iterations.
  - DONE->IDLE unconditionally.
  - CALC->IDLE on annul.
- Timing: start high in cycle 0 -> CALC in cycles 1..WIDTH (one quotient bit per cycle, MSB first) -> DONE in cycle WIDTH+1 -> done=1 in that cycle only. busy=1 in cycles 1..WIDTH+1.
- start while busy is ignored (no queueing). start in the same cycle as a DONE->IDLE transition is also ignored. A new op is accepted in the following cycle at the earliest.
- Operand capture: in cycle 0, register the magnitudes. For signed ops, |x| is the two's-complement negation when the MSB is 1, treated as a WIDTH-bit unsigned value, so the most-negative value maps to 2^(WIDTH-1). Also register sign flags: neg_q = sign(dividend) XOR sign(divisor); neg_r = sign(dividend). Both flags are 0 for unsigned ops.
- Iteration: partial remainder is WIDTH+1 bits. Shift left one bit and bring in the next dividend bit. Trial-subtract |divisor|. If the result is non-negative, keep it and set the quotient bit to 1; else restore and set the bit to 0.
- Result commit (entering DONE): quotient = neg_q ? -q : q; remainder = neg_r ? -r : r. Both are truncated to WIDTH.
  - Signed most-negative / -1 yields quotient = most-negative value and remainder = 0, with no flag.
- Divide by zero (divisor==0 at capture): skip CALC, going IDLE->DONE directly, so done is in cycle 1. quotient = all ones, remainder = dividend unmodified, div_by_zero=1. All other completions set div_by_zero=0.
- annul:
  - In CALC: next state IDLE, no done, outputs retain previous op's values.
  - In DONE: no effect, and the done pulse still occurs.
  - In IDLE: no effect; annul together with start in IDLE -> start is ignored.
- Outputs change only on the DONE-entry edge or on rst.

Optional Feature:
- Macro name: DIV_EARLY_OUT_EN.
- When defined:
  - If divisor != 0 and |divisor| > |dividend| at capture, skip CALC: IDLE->DONE, done in cycle 1.
  - quotient = 0, remainder = dividend unmodified (sign preserved).
  - Likewise, if |divisor| == 1, skip CALC: quotient = neg_q ? -|dividend| : |dividend|, remainder = 0, done in cycle 1.
- When undefined: these cases take the full WIDTH+1 latency with identical numeric results.

Test Plan:
- Unsigned: dividend=100, divisor=7, signed_div=0, start pulse -> done exactly in cycle 33; quotient=14, remainder=2; busy high cycles 1..33; div_by_zero=0.
- Signed: dividend=-100 (0xFFFFFF9C), divisor=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). Also dividend=0x80000000, divisor=0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
- Divide by zero: dividend=0x12345678, divisor=0 -> done in cycle 1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Flush: start 50/5, annul in cycle 10 -> busy falls in cycle 11, no done pulse, outputs keep prior values. A start in cycle 11 is then accepted normally.
- Back-pressure/reset: start repeated in cycles 1..20 is ignored and yields a single done. rst asserted in cycle 15 of a divide -> next cycle busy=0, done=0, quotient=0, remainder=0, and no done follows.
- With DIV_EARLY_OUT_EN: 3/10 unsigned -> done in cycle 1, quotient=0, remainder=3. -9/1 signed -> quotient=-9, remainder=0, cycle 1. Without the macro, the same operands give done in cycle 33 with identical values.
